// File: rtl/linear_network_unicast_comb_pkg.sv
// Shared constants and packet layout for the linear unicast network.
// Modules size their own packets from parameters; pkt_t is the default-width view.
package linear_network_unicast_comb_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_NODE   = 4;
    localparam int DEFAULT_CMD_WIDTH  = $clog2(DEFAULT_NUM_NODE);

    typedef struct packed {
        logic                          valid;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
        logic [DEFAULT_CMD_WIDTH-1:0]  dest;
    } pkt_t;

endpackage

// File: rtl/linear_network_unicast_comb_node.sv
// One chain stage: registered packet, tag compare against NODE_ID, delivery/forward decode.
// A packet delivered here continues downstream as a bubble so it lands at exactly one node.
module linear_network_node #(
    parameter int DATA_WIDTH    = 32,
    parameter int COMMAND_WIDTH = 2,
    parameter int NODE_ID       = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic [COMMAND_WIDTH-1:0] in_dest,
    output logic                     fwd_valid,
    output logic [DATA_WIDTH-1:0]    fwd_data,
    output logic [COMMAND_WIDTH-1:0] fwd_dest,
    output logic                     dlv_valid,
    output logic [DATA_WIDTH-1:0]    dlv_data
);

    logic                     pkt_valid;
    logic [DATA_WIDTH-1:0]    pkt_data;
    logic [COMMAND_WIDTH-1:0] pkt_dest;
    logic                     hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
            pkt_dest  <= '0;
        end else if (en) begin
            pkt_valid <= in_valid;
            pkt_data  <= in_data;
            pkt_dest  <= in_dest;
        end
    end

    assign hit       = pkt_valid && (pkt_dest == COMMAND_WIDTH'(NODE_ID));
    assign dlv_valid = en && hit;
    assign dlv_data  = dlv_valid ? pkt_data : '0;
    assign fwd_valid = pkt_valid && !hit;
    assign fwd_data  = pkt_data;
    assign fwd_dest  = pkt_dest;

endmodule

// File: rtl/linear_network_unicast_comb.sv
// Linear chain of NUM_NODE stages; a packet tagged k is delivered k enabled edges after injection.
// Packets whose tag matches no node fall off the end of the chain.
module linear_network_unicast_comb
    import linear_network_unicast_comb_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int NUM_NODE      = DEFAULT_NUM_NODE,
    parameter int COMMAND_WIDTH = $clog2(NUM_NODE)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_valid,
    input  logic [DATA_WIDTH-1:0]          i_data_bus,
    input  logic                           i_en,
    input  logic [COMMAND_WIDTH-1:0]       i_cmd,
    output logic [NUM_NODE-1:0]            o_valid,
    output logic [NUM_NODE*DATA_WIDTH-1:0] o_data_bus
);

    // Element k feeds stage k; element NUM_NODE is what drops off the tail.
    logic                     chain_valid [NUM_NODE+1];
    logic [DATA_WIDTH-1:0]    chain_data  [NUM_NODE+1];
    logic [COMMAND_WIDTH-1:0] chain_dest  [NUM_NODE+1];
    logic                     tail_unused;

    assign chain_valid[0] = i_valid;
    assign chain_data[0]  = i_data_bus;
    assign chain_dest[0]  = i_cmd;

    genvar k;
    generate
        for (k = 0; k < NUM_NODE; k++) begin : g_node
            linear_network_node #(
                .DATA_WIDTH    (DATA_WIDTH),
                .COMMAND_WIDTH (COMMAND_WIDTH),
                .NODE_ID       (k)
            ) u_node (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (i_en),
                .in_valid  (chain_valid[k]),
                .in_data   (chain_data[k]),
                .in_dest   (chain_dest[k]),
                .fwd_valid (chain_valid[k+1]),
                .fwd_data  (chain_data[k+1]),
                .fwd_dest  (chain_dest[k+1]),
                .dlv_valid (o_valid[k]),
                .dlv_data  (o_data_bus[k*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    assign tail_unused = ^{chain_valid[NUM_NODE], chain_data[NUM_NODE], chain_dest[NUM_NODE]};

endmodule

// File: tb/tb_linear_network_unicast_comb.sv
// Scoreboard bench for linear_network_unicast_comb (32-bit data, 4 nodes).
module tb_linear_network_unicast_comb;
    import linear_network_unicast_comb_pkg::*;

    localparam int DW = 32;
    localparam int NN = 4;
    localparam int CW = 2;
    localparam int BW = DW * NN;
    localparam int EW = 32 + 8 + DW;

    logic          clk;
    logic          rst_n;
    logic          i_valid;
    logic [DW-1:0] i_data_bus;
    logic          i_en;
    logic [CW-1:0] i_cmd;
    logic [NN-1:0] o_valid;
    logic [BW-1:0] o_data_bus;

    logic [EW-1:0] exp_q[$];
    int            n_checks;
    int            n_errors;
    int            ecount;

    linear_network_unicast_comb #(
        .DATA_WIDTH    (DW),
        .NUM_NODE      (NN),
        .COMMAND_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .i_en       (i_en),
        .i_cmd      (i_cmd),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, ecount);
        end
    endtask

    // Insert keeping the queue ordered by (due edge, node).
    task automatic push_exp(input int due, input int node, input logic [DW-1:0] data);
        logic [EW-1:0] entry;
        int pos;
        entry = {32'(due), 8'(node), data};
        pos = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i][EW-1:DW] > entry[EW-1:DW]) begin
                pos = i;
                break;
            end
        end
        exp_q.insert(pos, entry);
    endtask

    task automatic compare_outputs(input string tag);
        logic [NN-1:0] exp_v;
        logic [BW-1:0] exp_d;
        logic [EW-1:0] e;
        int node;
        exp_v = '0;
        exp_d = '0;
        if (i_en) begin
            while (exp_q.size() > 0 && int'(exp_q[0][EW-1:EW-32]) <= ecount) begin
                e = exp_q.pop_front();
                if (int'(e[EW-1:EW-32]) == ecount) begin
                    node = int'(e[DW+7:DW]);
                    exp_v[node] = 1'b1;
                    exp_d[node*DW +: DW] = e[DW-1:0];
                end
            end
        end
        check_eq({tag, "_valid"}, BW'(o_valid), BW'(exp_v));
        check_eq({tag, "_data"}, o_data_bus, exp_d);
    endtask

    // driver: one clock cycle with the given inputs
    task automatic drive_cycle(input string tag, input logic en, input logic v,
                               input logic [DW-1:0] data, input logic [CW-1:0] cmd);
        @(negedge clk);
        i_en       = en;
        i_valid    = v;
        i_data_bus = data;
        i_cmd      = cmd;
        if (en && v) push_exp(ecount + 1 + int'(cmd), int'(cmd), data);
        @(posedge clk);
        #1;
        if (en) ecount++;
        compare_outputs(tag);
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst_n      = 1'b0;
        i_en       = 1'b0;
        i_valid    = 1'b0;
        i_data_bus = '0;
        i_cmd      = 2'd3;
        exp_q.delete();
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            check_eq("reset_valid", BW'(o_valid), '0);
            check_eq("reset_data", o_data_bus, '0);
            @(negedge clk);
            i_en    = (c == cycles - 1);
            i_valid = (c == cycles - 1);
        end
        i_en    = 1'b0;
        i_valid = 1'b0;
        rst_n   = 1'b1;
        ecount  = 0;
    endtask

    initial begin
        pkt_t rnd;
        n_checks   = 0;
        n_errors   = 0;
        ecount     = 0;
        rst_n      = 1'b0;
        i_en       = 1'b0;
        i_valid    = 1'b0;
        i_data_bus = '0;
        i_cmd      = 2'd3;

        apply_reset(4);

        // single packet to node 1, visible one cycle only
        drive_cycle("single", 1'b1, 1'b1, 32'hAAAAAAAA, 2'd1);
        for (int c = 0; c < 5; c++) drive_cycle("single", 1'b1, 1'b0, '0, 2'd0);

        // packet to node 2 with a 3-cycle stall after injection
        drive_cycle("stall", 1'b1, 1'b1, 32'hAAAAAAAA, 2'd2);
        for (int c = 0; c < 3; c++) drive_cycle("stall", 1'b0, 1'b0, '0, 2'd0);
        for (int c = 0; c < 4; c++) drive_cycle("stall", 1'b1, 1'b0, '0, 2'd0);

        // back-to-back packets to different nodes
        drive_cycle("b2b", 1'b1, 1'b1, 32'hAAAAAAAA, 2'd3);
        drive_cycle("b2b", 1'b1, 1'b1, 32'hBBBBBBBB, 2'd0);
        for (int c = 0; c < 5; c++) drive_cycle("b2b", 1'b1, 1'b0, '0, 2'd0);

        // bubbles carrying data never reach outputs
        for (int c = 0; c < 5; c++) drive_cycle("bubble", 1'b1, 1'b0, 32'hBBBBBBBB, 2'd2);
        // stalled input with valid high is not injected
        for (int c = 0; c < 3; c++) drive_cycle("noinj", 1'b0, 1'b1, 32'hCCCCCCCC, 2'd0);
        for (int c = 0; c < 3; c++) drive_cycle("noinj", 1'b1, 1'b0, '0, 2'd0);

        // reset mid-flight drops the packet heading for node 3
        drive_cycle("midrst", 1'b1, 1'b1, 32'hDDDDDDDD, 2'd3);
        drive_cycle("midrst", 1'b1, 1'b0, '0, 2'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_async_valid", BW'(o_valid), '0);
        check_eq("midrst_async_data", o_data_bus, '0);
        apply_reset(2);
        for (int c = 0; c < 6; c++) drive_cycle("postrst", 1'b1, 1'b0, '0, 2'd0);

        // random traffic with random stalls
        for (int c = 0; c < 400; c++) begin
            rnd.valid = ($urandom_range(0, 3) != 0);
            rnd.data  = $urandom;
            rnd.dest  = CW'($urandom_range(0, NN - 1));
            drive_cycle("rand", ($urandom_range(0, 3) != 0), rnd.valid, rnd.data, rnd.dest);
        end
        for (int c = 0; c < 8; c++) drive_cycle("drain", 1'b1, 1'b0, '0, 2'd0);
        check_eq("queue_empty", BW'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
